// File: rtl/uibi_lsu_master.sv
// Load/store master for the UIBI bus. It takes one CPU access, runs it as a
// single bus transfer, and returns a one-cycle completion pulse. That pulse
// carries the error status and the extended load data.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for cpu_req; the access is captured on the accepting edge
//   BUS   | bus_req asserted; waiting for bus_ready or for the wait limit
//   RESP  | cpu_done pulse with cpu_err/cpu_rdata, then back to IDLE
module uibi_lsu_master #(
    parameter int XLEN        = 32,
    parameter int SLAVE_WIDTH = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        cpu_req,
    input  logic                        cpu_wen,
    input  logic [XLEN-1:0]             cpu_addr,
    input  logic [1:0]                  cpu_size,
    input  logic                        cpu_unsigned,
    input  logic [XLEN-1:0]             cpu_wdata,
    output logic                        cpu_busy,
    output logic                        cpu_done,
    output logic                        cpu_err,
    output logic [XLEN-1:0]             cpu_rdata,

    input  logic [XLEN-1:0]             bus_dat_i,
    output logic [XLEN-1:0]             bus_dat_o,
    output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
    output logic [SLAVE_WIDTH-1:0]      bus_num,
    output logic                        bus_req,
    output logic                        bus_wen,
    output logic [2:0]                  bus_mode,
    input  logic                        bus_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TIMEOUT_VAL = (CW + 1)'(TIMEOUT);

    localparam logic [2:0] MODE_NULL = 3'b000;
    localparam logic [2:0] MODE_BYTE = 3'b001;
    localparam logic [2:0] MODE_HALF = 3'b011;
    localparam logic [2:0] MODE_WORD = 3'b111;

    state_t            state;
    state_t            state_next;

    logic              wen_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;
    logic [XLEN-1:0]   rdata_q;
    logic [CW-1:0]     wait_cnt;

    logic              misaligned;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   load_shift;
    logic              sign_bit;
    logic [XLEN-1:0]   load_data;
    logic [CW:0]       wait_inc;
    logic              timeout_hit;
    logic [2:0]        mode_cur;

    // Alignment check on the live request; size 11 never goes on the bus.
    always_comb begin
        misaligned = 1'b0;
        case (cpu_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = cpu_addr[0];
            2'b10:   misaligned = (cpu_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Byte-lane steering for the captured access: store placement and load extraction/extension.
    always_comb begin
        shamt      = {addr_q[1:0], 3'b000};
        lane_mask  = XLEN'(32'hFFFF_FFFF);
        sign_bit   = 1'b0;
        mode_cur   = MODE_WORD;
        load_shift = bus_dat_i >> shamt;
        case (size_q)
            2'b00: begin
                lane_mask = XLEN'(8'hFF);
                sign_bit  = load_shift[7];
                mode_cur  = MODE_BYTE;
            end
            2'b01: begin
                lane_mask = XLEN'(16'hFFFF);
                sign_bit  = load_shift[15];
                mode_cur  = MODE_HALF;
            end
            default: begin
                lane_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = load_shift[31];
                mode_cur  = MODE_WORD;
            end
        endcase
        store_data = (wdata_q << shamt) & (lane_mask << shamt);
        load_data  = (load_shift & lane_mask) |
                     ((!uns_q && sign_bit) ? ~lane_mask : '0);
    end

    // The wait limit fires on the edge where the count would reach TIMEOUT,
    // so bus_req stays high for exactly TIMEOUT cycles.
    always_comb begin
        wait_inc    = {1'b0, wait_cnt} + (CW + 1)'(1);
        timeout_hit = (TIMEOUT != 0) && (wait_inc == TIMEOUT_VAL);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs; bus_ready wins over the wait limit.
    always_comb begin
        state_next = state;
        cpu_busy   = 1'b0;
        cpu_done   = 1'b0;
        cpu_err    = 1'b0;
        cpu_rdata  = '0;
        bus_req    = 1'b0;
        bus_wen    = 1'b0;
        bus_mode   = MODE_NULL;
        bus_dat_o  = '0;
        bus_addr   = '0;
        bus_num    = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                cpu_busy = 1'b1;
                bus_req  = 1'b1;
                bus_wen  = wen_q;
                bus_mode = mode_cur;
                bus_dat_o = store_data;
                bus_addr = addr_q[XLEN-SLAVE_WIDTH-1:0];
                bus_num  = addr_q[XLEN-1 -: SLAVE_WIDTH];
                if (bus_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cpu_busy   = 1'b1;
                cpu_done   = 1'b1;
                cpu_err    = err_q;
                cpu_rdata  = rdata_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Access capture, wait counting and response registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        wen_q    <= cpu_wen;
                        addr_q   <= cpu_addr;
                        size_q   <= cpu_size;
                        uns_q    <= cpu_unsigned;
                        wdata_q  <= cpu_wdata;
                        err_q    <= misaligned;
                        rdata_q  <= '0;
                        wait_cnt <= '0;
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        err_q   <= 1'b0;
                        rdata_q <= wen_q ? '0 : load_data;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_inc[CW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uibi_lsu_master.sv
// Directed bench for uibi_lsu_master (TIMEOUT overridden to 8).
module tb_uibi_lsu_master;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] bus_dat_i;
    logic [31:0] bus_dat_o;
    logic [27:0] bus_addr;
    logic [3:0]  bus_num;
    logic        bus_req;
    logic        bus_wen;
    logic [2:0]  bus_mode;
    logic        bus_ready;

    int n_tests = 0;
    int n_fail  = 0;

    uibi_lsu_master #(
        .XLEN(32),
        .SLAVE_WIDTH(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr),
        .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned),
        .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy),
        .cpu_done(cpu_done),
        .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .bus_dat_i(bus_dat_i),
        .bus_dat_o(bus_dat_o),
        .bus_addr(bus_addr),
        .bus_num(bus_num),
        .bus_req(bus_req),
        .bus_wen(bus_wen),
        .bus_mode(bus_mode),
        .bus_ready(bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic [31:0] exp_dat,
                            input logic [2:0] exp_mode);
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = addr; cpu_size = size;
        cpu_unsigned = 1'b0; cpu_wdata = wdata;
        tick;
        cpu_req = 1'b0;
        check({tag, " bus_req"}, 32'(bus_req), 32'd1);
        check({tag, " bus_dat_o"}, bus_dat_o, exp_dat);
        check({tag, " bus_mode"}, 32'(bus_mode), 32'(exp_mode));
        check({tag, " bus_wen"}, 32'(bus_wen), 32'd1);
        check({tag, " bus_num"}, 32'(bus_num), 32'(addr[31:28]));
        check({tag, " bus_addr"}, 32'(bus_addr), 32'(addr[27:0]));
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        check({tag, " done"}, 32'(cpu_done), 32'd1);
        check({tag, " err"}, 32'(cpu_err), 32'd0);
        check({tag, " rdata"}, cpu_rdata, 32'd0);
        check({tag, " bus_dat_o resp"}, bus_dat_o, 32'd0);
        tick;
        check({tag, " idle"}, 32'(cpu_busy), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] dat, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = addr; cpu_size = size;
        cpu_unsigned = uns; cpu_wdata = 32'h0;
        tick;
        cpu_req = 1'b0;
        check({tag, " bus_req"}, 32'(bus_req), 32'd1);
        check({tag, " bus_wen"}, 32'(bus_wen), 32'd0);
        bus_ready = 1'b1; bus_dat_i = dat;
        tick;
        bus_ready = 1'b0;
        check({tag, " done"}, 32'(cpu_done), 32'd1);
        check({tag, " err"}, 32'(cpu_err), 32'd0);
        check({tag, " rdata"}, cpu_rdata, exp);
        tick;
        check({tag, " done clear"}, 32'(cpu_done), 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic [31:0] addr, input logic [1:0] size);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = addr; cpu_size = size;
        cpu_unsigned = 1'b0; bus_ready = 1'b1;
        tick;
        cpu_req = 1'b0;
        check({tag, " bus_req"}, 32'(bus_req), 32'd0);
        check({tag, " done"}, 32'(cpu_done), 32'd1);
        check({tag, " err"}, 32'(cpu_err), 32'd1);
        check({tag, " rdata"}, cpu_rdata, 32'd0);
        tick;
        bus_ready = 1'b0;
        check({tag, " bus_req after"}, 32'(bus_req), 32'd0);
        check({tag, " done clear"}, 32'(cpu_done), 32'd0);
    endtask

    initial begin
        int req_cycles;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = 32'h0; cpu_size = 2'b00;
        cpu_unsigned = 1'b0; cpu_wdata = 32'h0; bus_dat_i = 32'h0; bus_ready = 1'b0;
        tick;
        cpu_req = 1'b1;
        tick;
        check("reset busy", 32'(cpu_busy), 32'd0);
        check("reset done", 32'(cpu_done), 32'd0);
        check("reset err", 32'(cpu_err), 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_wen", 32'(bus_wen), 32'd0);
        check("reset bus_mode", 32'(bus_mode), 32'd0);
        check("reset bus_dat_o", bus_dat_o, 32'd0);
        check("reset bus_addr", 32'(bus_addr), 32'd0);
        check("reset bus_num", 32'(bus_num), 32'd0);
        cpu_req = 1'b0;

        // Byte store accepted on the first edge after reset release.
        rst = 1'b0;
        do_store("st_byte", 32'h3000_0006, 2'b00, 32'h0000_00AB, 32'h00AB_0000, 3'b001);
        do_store("st_byte_mask", 32'h5000_0001, 2'b00, 32'hFFFF_FF5A, 32'h0000_5A00, 3'b001);
        do_store("st_half", 32'h0000_0002, 2'b01, 32'h1234_5678, 32'h5678_0000, 3'b011);
        do_store("st_word", 32'hF000_0008, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111);

        // Signed half load with four wait cycles.
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h1000_0002; cpu_size = 2'b01;
        cpu_unsigned = 1'b0; bus_dat_i = 32'h8001_1234;
        tick;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld_half_wait bus_req", 32'(bus_req), 32'd1);
            check("ld_half_wait mode", 32'(bus_mode), 32'b011);
            check("ld_half_wait done", 32'(cpu_done), 32'd0);
            tick;
        end
        check("ld_half_wait bus_num", 32'(bus_num), 32'd1);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        check("ld_half_s done", 32'(cpu_done), 32'd1);
        check("ld_half_s err", 32'(cpu_err), 32'd0);
        check("ld_half_s rdata", cpu_rdata, 32'hFFFF_8001);
        tick;

        do_load("ld_half_u", 32'h1000_0002, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_8001);
        do_load("ld_byte_s", 32'h2000_0003, 2'b00, 1'b0, 32'h9A00_0000, 32'hFFFF_FF9A);
        do_load("ld_byte_u", 32'h2000_0001, 2'b00, 1'b1, 32'h0000_F000, 32'h0000_00F0);
        do_load("ld_word", 32'h4000_0004, 2'b10, 1'b0, 32'h8765_4321, 32'h8765_4321);

        do_misaligned("mis_word", 32'h0000_0005, 2'b10);
        do_misaligned("mis_half", 32'h0000_0001, 2'b01);
        do_misaligned("mis_size3", 32'h0000_0000, 2'b11);

        // Timeout: bus_ready held low.
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0004; cpu_size = 2'b10;
        cpu_unsigned = 1'b0; bus_ready = 1'b0;
        tick;
        cpu_req = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_done) break;
            if (bus_req) req_cycles++;
            tick;
        end
        check("timeout bus_req cycles", 32'(req_cycles), 32'd8);
        check("timeout done", 32'(cpu_done), 32'd1);
        check("timeout err", 32'(cpu_err), 32'd1);
        check("timeout rdata", cpu_rdata, 32'd0);
        tick;

        // bus_ready on the same edge the limit would fire.
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0008; cpu_size = 2'b10;
        cpu_unsigned = 1'b0;
        tick;
        cpu_req = 1'b0;
        repeat (7) tick;
        check("prio bus_req", 32'(bus_req), 32'd1);
        bus_ready = 1'b1; bus_dat_i = 32'h0BAD_F00D;
        tick;
        bus_ready = 1'b0;
        check("prio done", 32'(cpu_done), 32'd1);
        check("prio err", 32'(cpu_err), 32'd0);
        check("prio rdata", cpu_rdata, 32'h0BAD_F00D);
        tick;

        // Reset mid-transaction.
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h7000_0010; cpu_size = 2'b10;
        cpu_wdata = 32'h1111_2222;
        tick;
        cpu_req = 1'b0;
        check("rst_mid bus_req before", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid bus_req", 32'(bus_req), 32'd0);
        check("rst_mid busy", 32'(cpu_busy), 32'd0);
        check("rst_mid bus_dat_o", bus_dat_o, 32'd0);
        tick;
        check("rst_mid done", 32'(cpu_done), 32'd0);
        rst = 1'b0;
        do_store("post_rst", 32'h7000_0010, 2'b10, 32'h1111_2222, 32'h1111_2222, 3'b111);

        // Back-to-back with cpu_req held high; inputs changed while busy are ignored.
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h6000_0003; cpu_size = 2'b00;
        cpu_wdata = 32'h0000_0077; bus_ready = 1'b1;
        tick;
        cpu_addr = 32'h9000_0000; cpu_wdata = 32'h0000_0000;
        #1;
        check("b2b bus_num held", 32'(bus_num), 32'd6);
        check("b2b dat held", bus_dat_o, 32'h7700_0000);
        tick;
        check("b2b done1", 32'(cpu_done), 32'd1);
        tick;
        check("b2b gap busy", 32'(cpu_busy), 32'd0);
        check("b2b gap bus_req", 32'(bus_req), 32'd0);
        tick;
        check("b2b second bus_req", 32'(bus_req), 32'd1);
        check("b2b second bus_num", 32'(bus_num), 32'd9);
        tick;
        check("b2b done2", 32'(cpu_done), 32'd1);
        cpu_req = 1'b0; bus_ready = 1'b0;
        tick;
        tick;
        check("b2b no queue", 32'(cpu_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
